// File: rtl/adc_channel_arbiter_pkg.sv
// rtl/adc_channel_arbiter_pkg.sv - shared types and constants for the ADC channel arbiter
package adc_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } arb_state_e;

    localparam int NCH_DEF  = 4;
    localparam int DW_DEF   = 16;
    localparam int TSTAMP_W = 32;

    function automatic int chw(input int nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/adc_channel_arbiter_if.sv
// rtl/adc_channel_arbiter_if.sv - channel inputs and tagged sample output; ADC_ARB_TSTAMP_EN adds out_tstamp
interface adc_channel_arbiter_if #(
    parameter int NCH = adc_arb_pkg::NCH_DEF,
    parameter int DW  = adc_arb_pkg::DW_DEF
);
    localparam int CHW = adc_arb_pkg::chw(NCH);

    logic [NCH-1:0]    ch_drdy;
    logic [NCH*DW-1:0] ch_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [CHW-1:0]    out_ch;
`ifdef ADC_ARB_TSTAMP_EN
    logic [adc_arb_pkg::TSTAMP_W-1:0] out_tstamp;

    modport master (input ch_drdy, ch_data, out_ready,
                    output out_valid, out_data, out_ch, out_tstamp);
    modport slave  (output ch_drdy, ch_data, out_ready,
                    input out_valid, out_data, out_ch, out_tstamp);
`else
    modport master (input ch_drdy, ch_data, out_ready,
                    output out_valid, out_data, out_ch);
    modport slave  (output ch_drdy, ch_data, out_ready,
                    input out_valid, out_data, out_ch);
`endif

endinterface

// File: rtl/adc_channel_arbiter_rr_pick.sv
// rtl/adc_channel_arbiter_rr_pick.sv - combinational round-robin search from a start pointer
module adc_arb_rr_pick #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] pend_i,
    input  logic [CHW-1:0] ptr_i,
    output logic           found_o,
    output logic [CHW-1:0] idx_o
);

    int c;

    // Scan from the farthest offset down so the closest pending channel wins last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        c       = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            c = (int'(ptr_i) + k) % NCH;
            if (pend_i[c]) begin
                found_o = 1'b1;
                idx_o   = c[CHW-1:0];
            end
        end
    end

endmodule

// File: rtl/adc_channel_arbiter.sv
// rtl/adc_channel_arbiter.sv - round-robin arbiter of NCH ADC sample channels onto one sink
// ADC_ARB_TSTAMP_EN: latch a free-running 32-bit timestamp per sample and forward it.
module adc_channel_arbiter
    import adc_arb_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic                  clk,
    input  logic                  nres,
    input  logic                  enable,
    input  logic                  overrun_clr,
    output logic [NCH-1:0]        overrun,
    adc_channel_arbiter_if.master bus
);

    localparam int CHW = chw(NCH);

    arb_state_e     state_q;
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] overrun_q;
    logic [DW-1:0]  hold_q [NCH];
    logic [CHW-1:0] rr_q;
    logic           out_valid_q;
    logic [DW-1:0]  out_data_q;
    logic [CHW-1:0] out_ch_q;

    logic           pick_found;
    logic [CHW-1:0] pick_idx;
    logic [CHW-1:0] rr_d;
    logic           load;
    logic [NCH-1:0] load_mask;
    logic [NCH-1:0] capture;
    logic [NCH-1:0] ov_evt;

`ifdef ADC_ARB_TSTAMP_EN
    logic [TSTAMP_W-1:0] ts_q;
    logic [TSTAMP_W-1:0] hold_ts_q [NCH];
    logic [TSTAMP_W-1:0] out_tstamp_q;
    assign bus.out_tstamp = out_tstamp_q;
`endif

    // Pending samples are invisible to the picker while disabled; they are dropped next edge.
    adc_arb_rr_pick #(.NCH(NCH), .CHW(CHW)) u_pick (
        .pend_i  (pend_q & {NCH{enable}}),
        .ptr_i   (rr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        load      = pick_found && ((state_q == IDLE) || bus.out_ready);
        load_mask = '0;
        if (load) load_mask[pick_idx] = 1'b1;
        capture   = bus.ch_drdy & {NCH{enable}};
        ov_evt    = capture & pend_q & ~load_mask;
        rr_d      = (pick_idx == CHW'(NCH - 1)) ? '0 : pick_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            overrun_q   <= '0;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            for (int i = 0; i < NCH; i++) hold_q[i] <= '0;
`ifdef ADC_ARB_TSTAMP_EN
            ts_q         <= '0;
            out_tstamp_q <= '0;
            for (int i = 0; i < NCH; i++) hold_ts_q[i] <= '0;
`endif
        end else begin
            // An overrun keeps the older held sample; the new one is dropped.
            for (int i = 0; i < NCH; i++) begin
                if (capture[i] && !ov_evt[i]) begin
                    hold_q[i] <= bus.ch_data[i*DW +: DW];
`ifdef ADC_ARB_TSTAMP_EN
                    hold_ts_q[i] <= ts_q;
`endif
                end
            end
`ifdef ADC_ARB_TSTAMP_EN
            ts_q <= ts_q + 1'b1;
`endif
            pend_q    <= enable ? ((pend_q & ~load_mask) | capture) : '0;
            overrun_q <= (overrun_clr ? '0 : overrun_q) | ov_evt;

            case (state_q)
                IDLE, VALID: begin
                    if (load) begin
                        out_data_q  <= hold_q[pick_idx];
                        out_ch_q    <= pick_idx;
                        out_valid_q <= 1'b1;
                        rr_q        <= rr_d;
                        state_q     <= VALID;
`ifdef ADC_ARB_TSTAMP_EN
                        out_tstamp_q <= hold_ts_q[pick_idx];
`endif
                    end else if (state_q == VALID && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_adc_channel_arbiter.sv
// tb/tb_adc_channel_arbiter.sv - directed self-checking bench for adc_channel_arbiter
module tb_adc_channel_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 16;

    logic           clk         = 1'b0;
    logic           nres        = 1'b0;
    logic           enable      = 1'b0;
    logic           overrun_clr = 1'b0;
    logic [NCH-1:0] overrun;

    int n_pass  = 0;
    int n_total = 0;

    adc_channel_arbiter_if #(.NCH(NCH), .DW(DW)) bus ();

    adc_channel_arbiter #(.NCH(NCH), .DW(DW)) dut (
        .clk         (clk),
        .nres        (nres),
        .enable      (enable),
        .overrun_clr (overrun_clr),
        .overrun     (overrun),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [DW-1:0] d);
        bus.ch_drdy[c]           = 1'b1;
        bus.ch_data[c*DW +: DW] = d;
    endtask

    task automatic do_reset();
        bus.ch_drdy   = '0;
        bus.ch_data   = '0;
        bus.out_ready = 1'b1;
        enable        = 1'b1;
        overrun_clr   = 1'b0;
        nres          = 1'b0;
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_data", 32'(bus.out_data), 32'h0);
        check("rst_ch", 32'(bus.out_ch), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        nres = 1'b1;
        tick();
    endtask

    initial begin
        bus.ch_drdy   = '0;
        bus.ch_data   = '0;
        bus.out_ready = 1'b1;

        // Single sample on channel 2
        do_reset();
        set_ch(2, 16'h1234);
        tick();
        bus.ch_drdy = '0;
        check("single_lat_valid", 32'(bus.out_valid), 32'h0);
        tick();
        check("single_valid", 32'(bus.out_valid), 32'h1);
        check("single_data", 32'(bus.out_data), 32'h1234);
        check("single_ch", 32'(bus.out_ch), 32'h2);
        tick();
        check("single_done", 32'(bus.out_valid), 32'h0);

        // All four channels in one cycle, pointer at 0
        do_reset();
        for (int c = 0; c < NCH; c++) set_ch(c, 16'hA000 + 16'(c));
        tick();
        bus.ch_drdy = '0;
        for (int c = 0; c < NCH; c++) begin
            tick();
            check("sim_valid", 32'(bus.out_valid), 32'h1);
            check("sim_ch", 32'(bus.out_ch), 32'(c));
            check("sim_data", 32'(bus.out_data), 32'hA000 + 32'(c));
        end
        tick();
        check("sim_end", 32'(bus.out_valid), 32'h0);
        check("sim_overrun", 32'(overrun), 32'h0);

        // Backpressure and overrun on channel 1
        do_reset();
        bus.out_ready = 1'b0;
        set_ch(1, 16'h1111);
        tick();
        bus.ch_drdy = '0;
        tick();
        check("bp_valid", 32'(bus.out_valid), 32'h1);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) set_ch(1, 16'h2222);
            if (i == 5) set_ch(1, 16'hBEEF);
            tick();
            bus.ch_drdy = '0;
            check("bp_data_stable", 32'(bus.out_data), 32'h1111);
            check("bp_ch_stable", 32'(bus.out_ch), 32'h1);
        end
        check("bp_overrun", 32'(overrun), 32'h2);
        bus.out_ready = 1'b1;
        tick();
        check("bp_second_valid", 32'(bus.out_valid), 32'h1);
        check("bp_second_data", 32'(bus.out_data), 32'h2222);
        tick();
        check("bp_no_beef", 32'(bus.out_valid), 32'h0);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("bp_clr", 32'(overrun), 32'h0);

        // Fairness: channels 0 and 3 strobing every cycle
        do_reset();
        set_ch(0, 16'h0C00);
        set_ch(3, 16'h0C03);
        tick();
        tick();
        check("fair_first", 32'(bus.out_ch), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("fair_valid", 32'(bus.out_valid), 32'h1);
            check("fair_ch", 32'(bus.out_ch), (k % 2 == 1) ? 32'h3 : 32'h0);
            check("fair_data", 32'(bus.out_data), (k % 2 == 1) ? 32'h0C03 : 32'h0C00);
        end
        check("fair_overrun", 32'(overrun), 32'h9);
        overrun_clr = 1'b1;
        tick();
        check("clr_evt_wins", 32'(overrun), 32'h8);
        bus.ch_drdy = '0;
        tick();
        overrun_clr = 1'b0;
        check("clr_all", 32'(overrun), 32'h0);

        // Asynchronous reset while a word is in flight
        do_reset();
        bus.out_ready = 1'b0;
        set_ch(1, 16'h1111);
        set_ch(2, 16'h2222);
        tick();
        bus.ch_drdy = '0;
        tick();
        set_ch(2, 16'h2223);
        tick();
        bus.ch_drdy = '0;
        check("mid_pre_overrun", 32'(overrun), 32'h4);
        check("mid_pre_valid", 32'(bus.out_valid), 32'h1);
        #2;
        nres = 1'b0;
        #1;
        check("mid_async_valid", 32'(bus.out_valid), 32'h0);
        check("mid_async_overrun", 32'(overrun), 32'h0);
        check("mid_async_data", 32'(bus.out_data), 32'h0);
        tick();
        nres = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_stale", 32'(bus.out_valid), 32'h0);
        end
        set_ch(3, 16'h3333);
        tick();
        bus.ch_drdy = '0;
        check("mid_new_lat", 32'(bus.out_valid), 32'h0);
        tick();
        check("mid_new_valid", 32'(bus.out_valid), 32'h1);
        check("mid_new_ch", 32'(bus.out_ch), 32'h3);
        check("mid_new_data", 32'(bus.out_data), 32'h3333);

        // Enable drop discards pending channel 2
        do_reset();
        bus.out_ready = 1'b0;
        set_ch(1, 16'h0101);
        set_ch(2, 16'h0202);
        tick();
        bus.ch_drdy = '0;
        tick();
        check("en_first_ch", 32'(bus.out_ch), 32'h1);
        enable = 1'b0;
        tick();
        check("en_inflight", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        tick();
        check("en_drop_pend", 32'(bus.out_valid), 32'h0);
        set_ch(2, 16'h0BAD);
        tick();
        bus.ch_drdy = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_ignore_drdy", 32'(bus.out_valid), 32'h0);
        end
        enable = 1'b1;
        tick();
        tick();
        check("en_reenable_idle", 32'(bus.out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_channel_arbiter.md
Name: adc_channel_arbiter

Overview:
Round-robin scheduler that shares one downstream sample sink (logger FIFO/writer) between NCH decimated ADC channels. Each channel is an SPI ADC plus decimation pair that emits one-cycle drdy pulses with a 16-bit word. The block buffers one sample per channel, grants the sink fairly, and tags each word with its channel number. It also flags per-channel overruns when a channel produces a new sample before its previous one was forwarded.

Parameters:
NCH, 4, number of ADC channels (2..8)
DW, 16, sample width in bits
CHW, $clog2(NCH), channel tag width (derived; not overridden)

Ports:
clk  in  1  system clock
nres  in  1  asynchronous active-low reset
enable  in  1  accept new samples when high
ch_drdy  in  NCH  per-channel one-cycle sample strobe (bit i = channel i)
ch_data  in  NCH*DW  packed samples; channel i at [i*DW +: DW]
out_valid  out  1  output word valid
out_ready  in  1  sink accepts word when high with out_valid
out_data  out  DW  forwarded sample
out_ch  out  CHW  channel tag of out_data
overrun  out  NCH  sticky per-channel overrun flags
overrun_clr  in  1  clears all overrun flags

Behaviour:
- Reset (nres low, async): out_valid=0, out_data=0, out_ch=0, overrun=0, all pending flags=0, RR pointer=0, state=IDLE.
- Capture: a channel with ch_drdy[i]=1 and enable=1 loads hold[i]=ch_data slice and sets pend[i] on the next edge. ch_drdy while enable=0 is ignored.
- Overrun: ch_drdy[i] while pend[i]=1 and channel i not being transferred to the output register this cycle -> overrun[i] set (sticky). Held sample kept; new sample dropped.
- Simultaneous drdy and load of the same channel: the new sample is captured, pend[i] stays 1, no overrun.
- overrun_clr clears all flags. A same-cycle overrun event wins and its bit is set.
- FSM IDLE: if any pend, pick the first pending channel searching from the RR pointer upward with wrap. Load out_data/out_ch, clear that pend bit, set out_valid, RR pointer = granted+1 mod NCH, go to VALID.
- FSM VALID: out_valid, out_data and out_ch stay stable until out_valid&&out_ready.
  - On the handshake, if another channel is pending, load the next winner in the same cycle (back-to-back, no bubble) and stay in VALID.
  - Otherwise deassert out_valid and return to IDLE.
- Latency: drdy at edge t -> pend at t+1 -> out_valid at t+2 when idle. Sustained throughput is 1 word/cycle with out_ready held high.
- enable low: pend bits cleared on the next edge. An in-flight out_valid word still completes its handshake. overrun is unaffected.
- Fairness: a channel pending continuously is granted within NCH grants.

Optional Feature:
ADC_ARB_TSTAMP_EN
- Defined: adds output out_tstamp (32 bits), driven from a free-running 32-bit counter (reset 0, wraps). The counter value is latched per channel at capture and forwarded alongside out_data with identical timing and stability rules.
- Undefined: no counter, no port, no extra storage.

Decomposition:
- Package adc_arb_pkg holds:
  - state enum {IDLE, VALID}
  - default NCH/DW constants
  - TSTAMP_W=32
  - a function returning the channel tag width
- One sub-module, adc_arb_rr_pick: purely combinational. Inputs pend vector and RR pointer; outputs a found flag and the winning index. Instantiated once.

Test Plan:
- Single sample: enable=1, out_ready=1, ch_drdy=0b0100 with 0x1234 at cycle 0 -> out_valid=1 at cycle 2 with out_data=0x1234, out_ch=2; out_valid=0 at cycle 3.
- Simultaneous: all four drdy in one cycle with 0xA000..0xA003, pointer=0 -> four consecutive valid words on channels 0,1,2,3 with no bubble; overrun=0.
- Backpressure: out_ready=0 for 10 cycles with ch1 pending -> out_data/out_ch stable. A second ch1 drdy (0xBEEF) sets overrun[1], and 0xBEEF is never output.
- Fairness: ch0 and ch3 drdy every cycle, out_ready=1 -> grants alternate 0,3,0,3…; overrun bits set for both.
- Reset mid-transfer: nres low while out_valid=1 -> out_valid, overrun and pend cleared immediately (asynchronously). First output after release comes only from new drdy.
- enable drop: ch2 pending, enable=0 -> ch2 is never output; a subsequent drdy with enable=0 produces nothing.
